// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port of the PC/IR fetch stage: single outstanding
// req/ack read, address held stable while the request is up.
interface pc_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC / instruction-register stage feeding the controller FSM.
// Optional macro PC_BREAKPOINT_EN adds a PC breakpoint that blocks fetches.
//
// state  | meaning
// S_IDLE | no fetch outstanding, IR holds last word
// S_WAIT | imem_req up, waiting for imem_ack or timeout
module pc_fetch_unit #(
    parameter int PC_W        = 8,
    parameter int INSTR_W     = 8,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clb,
    input  logic              incPC,
    input  logic              loadPC,
    input  logic              selPC,
    input  logic              loadIR,
    input  logic [DATA_W-1:0] reg_data,
    pc_fetch_unit_if.master   imem,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_busy,
    output logic              fetch_err
`ifdef PC_BREAKPOINT_EN
    ,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              bp_en,
    output logic              bp_hit
`endif
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               fetch_go;
    logic               hold;

`ifdef PC_BREAKPOINT_EN
    logic hold_q, hold_d;
    logic hit_q, hit_d;

    // A breakpoint hit swallows the loadIR and parks the stage until bp_en drops.
    always_comb begin
        hold_d   = hold_q;
        hit_d    = hit_q;
        fetch_go = 1'b0;
        if (state_q == S_IDLE) begin
            if (hold_q) begin
                if (!bp_en) hold_d = 1'b0;
            end else if (loadIR) begin
                if (bp_en && (pc_q == bp_addr)) begin
                    hold_d = 1'b1;
                    hit_d  = 1'b1;
                end else begin
                    fetch_go = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            hold_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            hit_q  <= hit_d;
        end
    end

    assign hold   = hold_q;
    assign bp_hit = hit_q;
`else
    assign fetch_go = loadIR && (state_q == S_IDLE);
    assign hold     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_go) begin
                    state_d = S_WAIT;
                    addr_d  = pc_q;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                // ack on the expiry edge still wins
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_IDLE;
                end else if ((ACK_TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
                    ir_d    = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (ACK_TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (loadPC) pc_d = selPC ? PC_W'(reg_data) : PC_W'(ir_q[3:0]);
        else if (incPC) pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign imem.imem_req  = (state_q == S_WAIT);
    assign imem.imem_addr = addr_q;
    assign opcode         = ir_q[INSTR_W-1 -: 4];
    assign operand        = ir_q[3:0];
    assign pc             = pc_q;
    assign fetch_busy     = (state_q == S_WAIT) || hold;
    assign fetch_err      = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus pushes expected fetch results,
// a monitor pops and compares each time fetch_busy falls.
module tb_pc_fetch_unit;
    logic       clk = 1'b0;
    logic       clb;
    logic       incPC, loadPC, selPC, loadIR;
    logic [7:0] reg_data;
    logic [3:0] opcode, operand;
    logic [7:0] pc;
    logic       fetch_busy, fetch_err;
    logic [7:0] mem_data;
    logic       mem_ack, stray_ack;
    int         mem_delay;
    int         wait_cnt;
    bit         ack_done;
`ifdef PC_BREAKPOINT_EN
    logic [7:0] bp_addr;
    logic       bp_en;
    logic       bp_hit;
`endif

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [3:0] opc;
        logic [3:0] opd;
        logic       err;
        logic [7:0] addr;
        int         len;
        bit         bp;
    } exp_t;
    exp_t sb[$];

    pc_fetch_unit_if #(.PC_W(8), .INSTR_W(8)) mif ();

    assign mif.imem_rdata = mem_data;
    assign mif.imem_ack   = mem_ack | stray_ack;

    pc_fetch_unit #(.PC_W(8), .INSTR_W(8), .DATA_W(8), .ACK_TIMEOUT(15)) dut (
        .clk        (clk),
        .clb        (clb),
        .incPC      (incPC),
        .loadPC     (loadPC),
        .selPC      (selPC),
        .loadIR     (loadIR),
        .reg_data   (reg_data),
        .imem       (mif.master),
        .opcode     (opcode),
        .operand    (operand),
        .pc         (pc),
        .fetch_busy (fetch_busy),
        .fetch_err  (fetch_err)
`ifdef PC_BREAKPOINT_EN
        ,
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .bp_hit     (bp_hit)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] opc, input logic [3:0] opd, input logic err,
                        input logic [7:0] addr, input int len, input bit bp);
        exp_t e;
        e.opc = opc; e.opd = opd; e.err = err; e.addr = addr; e.len = len; e.bp = bp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_sb(input int max);
        int k = 0;
        while (sb.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        check("sb_drain_pending", sb.size(), 0);
    endtask

    // Memory: acks mem_delay negedges after it first sees the request.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mif.imem_req && !ack_done) begin
            if (wait_cnt == mem_delay) begin
                mem_ack  = 1'b1;
                ack_done = 1'b1;
            end
            wait_cnt++;
        end else if (!mif.imem_req) begin
            wait_cnt = 0;
            ack_done = 1'b0;
        end
    end

    logic       busy_prev = 1'b0;
    logic       req_prev  = 1'b0;
    logic [7:0] req_addr  = '0;
    bit         req_seen  = 1'b0;
    int         busy_len  = 0;

    always @(negedge clk) begin
        exp_t e;
        if (fetch_busy && !busy_prev) begin
            busy_len = 0;
            req_seen = 1'b0;
        end
        if (mif.imem_req) begin
            if (!req_prev) req_addr = mif.imem_addr;
            else check("addr_stable", mif.imem_addr, req_addr);
            req_seen = 1'b1;
        end
        if (fetch_busy) busy_len++;
        if (!fetch_busy && busy_prev) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: got busy fall, expected none");
            end else begin
                e = sb.pop_front();
                if (e.bp) begin
                    check("bp_no_req", req_seen, 0);
`ifdef PC_BREAKPOINT_EN
                    check("bp_hit", bp_hit, 1);
`endif
                end else begin
                    check("opcode", opcode, e.opc);
                    check("operand", operand, e.opd);
                    check("fetch_err", fetch_err, e.err);
                    check("req_seen", req_seen, 1);
                    check("imem_addr", req_addr, e.addr);
                    if (e.len > 0) check("busy_len", busy_len, e.len);
                end
            end
        end
        busy_prev = fetch_busy;
        req_prev  = mif.imem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        clb = 1'b0; incPC = 0; loadPC = 0; selPC = 0; loadIR = 0; reg_data = '0;
        mem_data = '0; mem_delay = 0; stray_ack = 0; wait_cnt = 0; ack_done = 0;
`ifdef PC_BREAKPOINT_EN
        bp_addr = '0; bp_en = 0;
`endif
        repeat (2) tick();
        check("rst_pc", pc, 0);
        check("rst_opcode", opcode, 0);
        check("rst_operand", operand, 0);
        check("rst_req", mif.imem_req, 0);
        check("rst_addr", mif.imem_addr, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_err", fetch_err, 0);
        clb = 1'b1;
        tick();

        // basic fetch at pc 0
        mem_data = 8'h1D; mem_delay = 0;
        push(4'h1, 4'hD, 1'b0, 8'h00, 1, 1'b0);
        loadIR = 1; tick(); loadIR = 0;
        wait_sb(20);
        check("pc_after_fetch", pc, 8'h00);

        incPC = 1; repeat (3) tick(); incPC = 0;
        check("pc_inc3", pc, 8'h03);
        mem_data = 8'h37;
        push(4'h3, 4'h7, 1'b0, 8'h03, 1, 1'b0);
        loadIR = 1; tick(); loadIR = 0;
        wait_sb(20);

        // loadPC overrides incPC, operand target
        incPC = 1; loadPC = 1; selPC = 0; tick(); incPC = 0; loadPC = 0;
        check("pc_load_operand", pc, 8'h07);
        selPC = 1; reg_data = 8'hFF; loadPC = 1; tick(); loadPC = 0;
        check("pc_load_ff", pc, 8'hFF);
        incPC = 1; tick(); incPC = 0;
        check("pc_wrap", pc, 8'h00);
        reg_data = 8'hA5; loadPC = 1; tick(); loadPC = 0;
        check("pc_load_reg", pc, 8'hA5);

        // slow fetch; pc moves during WAIT, second loadIR in WAIT ignored
        mem_data = 8'h9C; mem_delay = 3;
        push(4'h9, 4'hC, 1'b0, 8'hA5, 4, 1'b0);
        loadIR = 1; incPC = 1; tick();
        tick();
        loadIR = 0; tick();
        incPC = 0;
        wait_sb(20);
        check("pc_during_wait", pc, 8'hA8);
        tick();
        check("no_second_fetch", mif.imem_req, 0);

        // ack in IDLE ignored
        mem_data = 8'hEE; stray_ack = 1; tick(); stray_ack = 0; tick();
        check("idle_ack_opcode", opcode, 4'h9);
        check("idle_ack_operand", operand, 4'hC);

        // timeout
        mem_data = 8'h55; mem_delay = 255;
        push(4'h0, 4'h0, 1'b1, 8'hA8, 15, 1'b0);
        loadIR = 1; tick(); loadIR = 0;
        wait_sb(40);
        check("to_req_low", mif.imem_req, 0);
        stray_ack = 1; tick(); stray_ack = 0; tick();
        check("to_late_ack_opcode", opcode, 4'h0);
        check("to_err_sticky", fetch_err, 1);

        // reset mid-WAIT
        clb = 0; tick(); clb = 1; tick();
        check("rst_clears_err", fetch_err, 0);
        reg_data = 8'h42; selPC = 1; loadPC = 1; tick(); loadPC = 0;
        check("pc_42", pc, 8'h42);
        push(4'h0, 4'h0, 1'b0, 8'h42, 0, 1'b0);
        loadIR = 1; tick(); loadIR = 0;
        tick();
        check("wait_req_up", mif.imem_req, 1);
        #2 clb = 0;
        #1;
        check("midrst_req", mif.imem_req, 0);
        check("midrst_pc", pc, 8'h00);
        check("midrst_busy", fetch_busy, 0);
        #1 clb = 1;
        wait_sb(5);
        mem_data = 8'hC3; stray_ack = 1; tick(); stray_ack = 0; tick();
        check("stray_opcode", opcode, 4'h0);
        check("stray_operand", operand, 4'h0);

`ifdef PC_BREAKPOINT_EN
        bp_addr = 8'h05; bp_en = 1;
        reg_data = 8'h05; selPC = 1; loadPC = 1; tick(); loadPC = 0;
        check("pc_05", pc, 8'h05);
        push(4'h0, 4'h0, 1'b0, 8'h00, 0, 1'b1);
        loadIR = 1; tick(); loadIR = 0;
        tick(); tick();
        check("bp_busy_held", fetch_busy, 1);
        check("bp_req_low", mif.imem_req, 0);
        bp_en = 0;
        wait_sb(10);
        mem_data = 8'h2B; mem_delay = 0;
        push(4'h2, 4'hB, 1'b0, 8'h05, 1, 1'b0);
        loadIR = 1; tick(); loadIR = 0;
        wait_sb(20);
        check("bp_hit_sticky", bp_hit, 1);
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
